// File: rtl/pkt_slot_ctrl_if.sv
// Packet slot controller bus: sample input, both packet RAM ports and the
// framer-side read handshake. The controller sits on the slave modport.
interface pkt_slot_ctrl_if #(
  parameter int SLOT_BITS = 2,
  parameter int WORD_BITS = 8
);
  localparam int AW = SLOT_BITS + WORD_BITS;

  logic          in_valid;
  logic [15:0]   in_data;
  logic          ram_we_a;
  logic [AW-1:0] ram_addr_a;
  logic [15:0]   ram_data_a;
  logic [AW:0]   ram_addr_b;
  logic [7:0]    ram_data_b;
  logic          pkt_ready;
  logic [15:0]   pkt_seq;
  logic          rd_start;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic [15:0]   drop_count;

  modport master (
    output in_valid, in_data, ram_data_b, rd_start, rd_en,
    input  ram_we_a, ram_addr_a, ram_data_a, ram_addr_b, pkt_ready, pkt_seq,
           rd_data, rd_valid, rd_last, drop_count
  );

  modport slave (
    input  in_valid, in_data, ram_data_b, rd_start, rd_en,
    output ram_we_a, ram_addr_a, ram_data_a, ram_addr_b, pkt_ready, pkt_seq,
           rd_data, rd_valid, rd_last, drop_count
  );
endinterface

// File: rtl/pkt_slot_ctrl.sv
// Packet slot controller: fills a ring of fixed-size slots in a 16-bit-write /
// 8-bit-read dual-port RAM, drops whole packets when the ring is full, and
// streams the oldest committed slot out byte by byte under framer flow control.
module pkt_slot_ctrl #(
  parameter int SLOT_BITS = 2,
  parameter int WORD_BITS = 8
) (
  input  logic           clk,
  input  logic           reset,
  pkt_slot_ctrl_if.slave bus
);
  localparam int AW    = SLOT_BITS + WORD_BITS;
  localparam int NSLOT = 1 << SLOT_BITS;
  localparam int CW    = SLOT_BITS + 1;
  localparam logic [WORD_BITS-1:0] WORD_LAST  = {WORD_BITS{1'b1}};
  localparam logic [WORD_BITS:0]   BYTE_LAST  = {(WORD_BITS+1){1'b1}};
  localparam logic [CW-1:0]        COUNT_FULL = CW'(NSLOT);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2} wr_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_BUSY = 1'b1} rd_state_t;

  wr_state_t            wr_state_r, wr_state_s;
  logic [WORD_BITS-1:0] word_cnt_r, word_cnt_s;
  logic [SLOT_BITS-1:0] wr_ptr_r, wr_ptr_s;
  logic [15:0]          seq_r, seq_s;
  logic [15:0]          drop_count_r, drop_count_s;
  logic                 ram_we_a_r, ram_we_a_s;
  logic [AW-1:0]        ram_addr_a_r, ram_addr_a_s;
  logic [15:0]          ram_data_a_r;
  logic                 commit_s;
  logic [15:0]          seq_mem_r [NSLOT];

  rd_state_t            rd_state_r, rd_state_s;
  logic [SLOT_BITS-1:0] rd_slot_r, rd_slot_s;
  logic [SLOT_BITS-1:0] rd_ptr_r, rd_ptr_s;
  logic [WORD_BITS:0]   byte_cnt_r, byte_cnt_s;
  logic                 release_s;
  logic                 rd_valid_r, rd_valid_s;
  logic                 rd_last_r, rd_last_s;
  logic [CW-1:0]        count_r, count_s;

  // Writer next state: accept or drop a packet on its first word, pack words, commit on the last.
  always_comb begin
    wr_state_s   = wr_state_r;
    word_cnt_s   = word_cnt_r;
    wr_ptr_s     = wr_ptr_r;
    seq_s        = seq_r;
    drop_count_s = drop_count_r;
    ram_we_a_s   = 1'b0;
    ram_addr_a_s = ram_addr_a_r;
    commit_s     = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        if (bus.in_valid) begin
          word_cnt_s = WORD_BITS'(1);
          // Full check uses the registered count so a same-cycle release cannot rescue the packet.
          if (count_r < COUNT_FULL) begin
            ram_we_a_s   = 1'b1;
            ram_addr_a_s = {wr_ptr_r, {WORD_BITS{1'b0}}};
            wr_state_s   = W_FILL;
          end else begin
            wr_state_s = W_DROP;
            seq_s      = seq_r + 16'd1;
            if (drop_count_r != 16'hFFFF) begin
              drop_count_s = drop_count_r + 16'd1;
            end else begin
              drop_count_s = drop_count_r;
            end
          end
        end else begin
          wr_state_s = W_IDLE;
        end
      end
      W_FILL: begin
        if (bus.in_valid) begin
          ram_we_a_s   = 1'b1;
          ram_addr_a_s = {wr_ptr_r, word_cnt_r};
          if (word_cnt_r == WORD_LAST) begin
            commit_s   = 1'b1;
            seq_s      = seq_r + 16'd1;
            wr_ptr_s   = wr_ptr_r + SLOT_BITS'(1);
            word_cnt_s = {WORD_BITS{1'b0}};
            wr_state_s = W_IDLE;
          end else begin
            word_cnt_s = word_cnt_r + WORD_BITS'(1);
          end
        end else begin
          wr_state_s = W_FILL;
        end
      end
      W_DROP: begin
        if (bus.in_valid) begin
          if (word_cnt_r == WORD_LAST) begin
            word_cnt_s = {WORD_BITS{1'b0}};
            wr_state_s = W_IDLE;
          end else begin
            word_cnt_s = word_cnt_r + WORD_BITS'(1);
          end
        end else begin
          wr_state_s = W_DROP;
        end
      end
      default: begin
        wr_state_s = W_IDLE;
        word_cnt_s = {WORD_BITS{1'b0}};
      end
    endcase
  end

  // Reader next state: latch the head slot on rd_start, step bytes on rd_en, release after the last byte.
  always_comb begin
    rd_state_s = rd_state_r;
    rd_slot_s  = rd_slot_r;
    byte_cnt_s = byte_cnt_r;
    rd_ptr_s   = rd_ptr_r;
    release_s  = 1'b0;
    rd_valid_s = 1'b0;
    rd_last_s  = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (bus.rd_start && (count_r != {CW{1'b0}})) begin
          rd_slot_s  = rd_ptr_r;
          byte_cnt_s = {(WORD_BITS+1){1'b0}};
          rd_state_s = R_BUSY;
        end else begin
          rd_state_s = R_IDLE;
        end
      end
      R_BUSY: begin
        if (bus.rd_en) begin
          rd_valid_s = 1'b1;
          if (byte_cnt_r == BYTE_LAST) begin
            rd_last_s  = 1'b1;
            release_s  = 1'b1;
            rd_ptr_s   = rd_ptr_r + SLOT_BITS'(1);
            byte_cnt_s = {(WORD_BITS+1){1'b0}};
            rd_state_s = R_IDLE;
          end else begin
            byte_cnt_s = byte_cnt_r + (WORD_BITS+1)'(1);
          end
        end else begin
          rd_state_s = R_BUSY;
        end
      end
      default: begin
        rd_state_s = R_IDLE;
      end
    endcase
  end

  // Committed-slot count: a commit and a release on the same edge cancel out.
  always_comb begin
    case ({commit_s, release_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // State and output registers for both sides; reset discards all packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_r   <= W_IDLE;
      word_cnt_r   <= {WORD_BITS{1'b0}};
      wr_ptr_r     <= {SLOT_BITS{1'b0}};
      seq_r        <= 16'd0;
      drop_count_r <= 16'd0;
      ram_we_a_r   <= 1'b0;
      ram_addr_a_r <= {AW{1'b0}};
      ram_data_a_r <= 16'd0;
      rd_state_r   <= R_IDLE;
      rd_slot_r    <= {SLOT_BITS{1'b0}};
      byte_cnt_r   <= {(WORD_BITS+1){1'b0}};
      rd_ptr_r     <= {SLOT_BITS{1'b0}};
      rd_valid_r   <= 1'b0;
      rd_last_r    <= 1'b0;
      count_r      <= {CW{1'b0}};
    end else begin
      wr_state_r   <= wr_state_s;
      word_cnt_r   <= word_cnt_s;
      wr_ptr_r     <= wr_ptr_s;
      seq_r        <= seq_s;
      drop_count_r <= drop_count_s;
      ram_we_a_r   <= ram_we_a_s;
      ram_addr_a_r <= ram_addr_a_s;
      ram_data_a_r <= bus.in_data;
      rd_state_r   <= rd_state_s;
      rd_slot_r    <= rd_slot_s;
      byte_cnt_r   <= byte_cnt_s;
      rd_ptr_r     <= rd_ptr_s;
      rd_valid_r   <= rd_valid_s;
      rd_last_r    <= rd_last_s;
      count_r      <= count_s;
    end
  end

  // Per-slot sequence numbers, captured when a slot commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        seq_mem_r[i] <= 16'd0;
      end
    end else if (commit_s) begin
      seq_mem_r[wr_ptr_r] <= seq_r;
    end
  end

  assign bus.ram_we_a   = ram_we_a_r;
  assign bus.ram_addr_a = ram_addr_a_r;
  assign bus.ram_data_a = ram_data_a_r;
  assign bus.ram_addr_b = {rd_slot_r, byte_cnt_r};
  assign bus.rd_data    = bus.ram_data_b;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.rd_last    = rd_last_r;
  assign bus.pkt_ready  = (count_r != {CW{1'b0}});
  assign bus.pkt_seq    = seq_mem_r[rd_ptr_r];
  assign bus.drop_count = drop_count_r;
endmodule
